// File: rtl/wvb_reader_pkg.sv
// Shared types and constants for the waveform buffer reader.
// Holds the FSM state enum, header field offsets and the end-of-event bit index.
package wvb_reader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_WAIT = 3'd1,
    HDR_OUT  = 3'd2,
    DATA     = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  // Header layout: stop address in the low field, start address directly above it.
  localparam int unsigned STOP_LSB = 0;
  localparam int unsigned EOE_BIT  = 0;

  // Start address LSB depends on the address width of the instance.
  function automatic int unsigned start_lsb(input int unsigned adr_w);
    return adr_w;
  endfunction

endpackage

// File: rtl/wvb_rd_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO holding sample words plus last tag.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset (flushes contents)
//   i_wr_en/i_wr_data  push side
//   i_rd_en            pop request, ignored when empty
//   o_rd_data/o_valid  head of FIFO, valid while not empty
//   o_count            current occupancy, used for read credits
module wvb_rd_fwft_fifo #(
  parameter int unsigned P_WIDTH     = 23,
  parameter int unsigned P_DEPTH     = 4,
  parameter int unsigned P_CNT_WIDTH = $clog2(P_DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic [P_WIDTH-1:0]     i_wr_data,
  input  logic                   i_rd_en,
  output logic [P_WIDTH-1:0]     o_rd_data,
  output logic                   o_valid,
  output logic [P_CNT_WIDTH-1:0] o_count
);

  localparam int unsigned LP_IW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

  logic [P_WIDTH-1:0]     r_mem [P_DEPTH];
  logic [LP_IW-1:0]       r_wr_idx;
  logic [LP_IW-1:0]       r_rd_idx;
  logic [P_CNT_WIDTH-1:0] r_count;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;

  function automatic logic [LP_IW-1:0] next_idx(input logic [LP_IW-1:0] idx);
    return (idx == LP_IW'(P_DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign w_full = (r_count == P_CNT_WIDTH'(P_DEPTH));
  assign w_pop  = i_rd_en && (r_count != '0);
  assign w_push = i_wr_en && (!w_full || w_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_idx <= next_idx(r_wr_idx);
      if (w_pop)  r_rd_idx <= next_idx(r_rd_idx);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_idx] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_idx];
  assign o_valid   = (r_count != '0);
  assign o_count   = r_count;

endmodule

// File: rtl/wvb_reader.sv
// Waveform buffer reader: pops one header per stored waveform, presents it on a
// valid/ready port, then streams samples start..stop (with wrap) from the buffer
// RAM through a credit-limited output FIFO.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_en                      allow starting a new event
//   i_hdr_empty/i_hdr_data_in/o_hdr_rdreq  header FIFO interface
//   o_wvb_rd_addr/i_wvb_data_in            buffer RAM read port
//   o_hdr_out/o_hdr_valid/i_hdr_ready      header output handshake
//   o_dout/o_dout_valid/o_dout_last/i_dout_ready  sample output handshake
//   o_busy                    not idle
//   o_eoe_err                 sticky end-of-event flag mismatch
module wvb_reader
  import wvb_reader_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH  = 22,
  parameter int unsigned P_ADR_WIDTH   = 12,
  parameter int unsigned P_HDR_WIDTH   = 80,
  parameter int unsigned P_RD_LATENCY  = 1,
  parameter int unsigned P_OFIFO_DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  i_hdr_data_in,
  output logic                    o_hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  o_wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] i_wvb_data_in,
  output logic [P_HDR_WIDTH-1:0]  o_hdr_out,
  output logic                    o_hdr_valid,
  input  logic                    i_hdr_ready,
  output logic [P_DATA_WIDTH-1:0] o_dout,
  output logic                    o_dout_valid,
  output logic                    o_dout_last,
  input  logic                    i_dout_ready,
  output logic                    o_busy,
  output logic                    o_eoe_err
);

  localparam int unsigned LP_START_LSB = start_lsb(P_ADR_WIDTH);
  localparam int unsigned LP_CNT_W     = $clog2(P_OFIFO_DEPTH + 1);
  localparam int unsigned LP_FW        = P_DATA_WIDTH + 1;

  state_t                  r_state;
  state_t                  w_next;
  logic [P_HDR_WIDTH-1:0]  r_hdr;
  logic [P_ADR_WIDTH-1:0]  r_rd_ptr;
  logic [P_ADR_WIDTH-1:0]  r_remaining;
  logic [P_RD_LATENCY-1:0] r_pv;      // read-in-flight valid, bit 0 newest
  logic [P_RD_LATENCY-1:0] r_pt;      // matching last tags
  logic                    r_eoe_err;

  logic                    w_hdr_rdreq;
  logic                    w_hdr_valid;
  logic                    w_busy;
  logic                    w_load;
  logic                    w_issue;
  logic [31:0]             w_used;
  logic                    w_fifo_wr;
  logic                    w_fifo_rd;
  logic                    w_fifo_valid;
  logic [LP_FW-1:0]        w_fifo_q;
  logic [LP_CNT_W-1:0]     w_fifo_cnt;
  logic [P_ADR_WIDTH-1:0]  w_hdr_start;
  logic [P_ADR_WIDTH-1:0]  w_hdr_stop;

  assign w_hdr_start = i_hdr_data_in[LP_START_LSB +: P_ADR_WIDTH];
  assign w_hdr_stop  = i_hdr_data_in[STOP_LSB +: P_ADR_WIDTH];

  // Slots committed after this edge: occupancy plus reads in flight, minus the same-cycle pop.
  assign w_used = 32'(w_fifo_cnt) + 32'($countones(r_pv)) - 32'(w_fifo_rd);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (i_en && !i_hdr_empty) w_next = HDR_WAIT;
      HDR_WAIT: w_next = HDR_OUT;
      HDR_OUT:  if (i_hdr_ready) w_next = DATA;
      DATA:     if (w_issue && (r_remaining == '0)) w_next = DRAIN;
      DRAIN:    if ((r_pv == '0) && !w_fifo_valid) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    w_hdr_rdreq = 1'b0;
    w_load      = 1'b0;
    w_hdr_valid = 1'b0;
    w_issue     = 1'b0;
    w_busy      = (r_state != IDLE);
    case (r_state)
      IDLE:     w_hdr_rdreq = i_en && !i_hdr_empty;
      HDR_WAIT: w_load      = 1'b1;
      HDR_OUT:  w_hdr_valid = 1'b1;
      DATA:     w_issue     = (w_used < 32'(P_OFIFO_DEPTH));
      default:  ;
    endcase
  end

  // Header capture, read pointer, in-flight pipe and sticky eoe check.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hdr       <= '0;
      r_rd_ptr    <= '0;
      r_remaining <= '0;
      r_pv        <= '0;
      r_pt        <= '0;
      r_eoe_err   <= 1'b0;
    end else begin
      if (w_load) begin
        r_hdr       <= i_hdr_data_in;
        r_rd_ptr    <= w_hdr_start;
        r_remaining <= w_hdr_stop - w_hdr_start;
      end else if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      // Shift toward the oldest slot; truncation drops the retiring entry.
      r_pv <= P_RD_LATENCY'({r_pv, w_issue});
      r_pt <= P_RD_LATENCY'({r_pt, (r_remaining == '0)});
      if (w_fifo_wr && (i_wvb_data_in[EOE_BIT] != r_pt[P_RD_LATENCY-1]))
        r_eoe_err <= 1'b1;
    end
  end

  assign w_fifo_wr = r_pv[P_RD_LATENCY-1];
  assign w_fifo_rd = w_fifo_valid && i_dout_ready;

  wvb_rd_fwft_fifo #(
    .P_WIDTH     (LP_FW),
    .P_DEPTH     (P_OFIFO_DEPTH),
    .P_CNT_WIDTH (LP_CNT_W)
  ) u_ofifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data ({i_wvb_data_in, r_pt[P_RD_LATENCY-1]}),
    .i_rd_en   (w_fifo_rd),
    .o_rd_data (w_fifo_q),
    .o_valid   (w_fifo_valid),
    .o_count   (w_fifo_cnt)
  );

  assign o_hdr_rdreq   = w_hdr_rdreq;
  assign o_wvb_rd_addr = r_rd_ptr;
  assign o_hdr_out     = r_hdr;
  assign o_hdr_valid   = w_hdr_valid;
  assign o_busy        = w_busy;
  assign o_eoe_err     = r_eoe_err;
  // Gate the head so stale storage never shows on an empty FIFO.
  assign o_dout_valid  = w_fifo_valid;
  assign o_dout        = w_fifo_valid ? w_fifo_q[LP_FW-1:1] : '0;
  assign o_dout_last   = w_fifo_valid && w_fifo_q[0];

endmodule
